// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a first-word-fall-through byte FIFO.
// Optional parity bit after the data bits when UART_TX_PARITY_EN is defined (sense from PARITY_ODD).
module uart_tx_fifo #(
   parameter int CLK_FREQ_HZ = 8000000,
   parameter int BAUD_RATE   = 115200,
   parameter int FIFO_DEPTH  = 8,
   parameter int STOP_BITS   = 1,
   parameter int PARITY_ODD  = 0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          tx_en,
   input  logic [7:0]                    data_i,
   input  logic                          valid_i,
   output logic                          ready_o,
   output logic                          uart_tx,
   output logic                          busy_o,
   output logic [$clog2(FIFO_DEPTH):0]   level_o
);
   localparam int BAUD_DIV = (CLK_FREQ_HZ + BAUD_RATE / 2) / BAUD_RATE;
   localparam int AW       = $clog2(FIFO_DEPTH);
   localparam int BW       = $clog2(BAUD_DIV + 1);
   localparam logic [BW-1:0] BAUD_LAST  = BW'(BAUD_DIV - 1);
   localparam logic [2:0]    STOP_LAST  = 3'(STOP_BITS - 1);
   localparam logic [AW:0]   DEPTH_FULL = FIFO_DEPTH[AW:0];

   // state    | meaning
   // S_IDLE   | line high, waiting for a queued byte with tx_en
   // S_START  | start bit (low)
   // S_DATA   | 8 data bits, LSB first
   // S_PARITY | parity bit (parity builds only)
   // S_STOP   | STOP_BITS stop bits (high); may chain straight into S_START
`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic          push, pop;
   logic [7:0]    head;

   assign ready_o = (count_q != DEPTH_FULL);
   assign push    = valid_i && ready_o;
   assign level_o = count_q;
   assign head    = mem_q[rd_ptr_q];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (pop && !push) count_q <= count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= data_i;
   end

   state_t        state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          busy_q, busy_d;
   logic          tick, can_start, start_frame;

`ifdef UART_TX_PARITY_EN
   logic          par_q, par_d;
`else
   logic          unused_parity_odd;
   assign unused_parity_odd = PARITY_ODD[0];
`endif

   assign tick      = (baud_q == '0);
   assign can_start = (count_q != '0) && tx_en;

   always_comb begin
      state_d     = state_q;
      baud_d      = tick ? BAUD_LAST : baud_q - 1'b1;
      bit_d       = bit_q;
      shift_d     = shift_q;
      tx_d        = tx_q;
      busy_d      = busy_q;
      pop         = 1'b0;
      start_frame = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d       = par_q;
`endif
      case (state_q)
         S_IDLE: begin
            tx_d        = 1'b1;
            busy_d      = 1'b0;
            baud_d      = baud_q;
            start_frame = can_start;
         end
         S_START: begin
            if (tick) begin
               tx_d    = shift_q[0];
               bit_d   = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (tick) begin
               if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  tx_d    = par_q;
                  state_d = S_PARITY;
`else
                  tx_d    = 1'b1;
                  bit_d   = STOP_LAST;
                  state_d = S_STOP;
`endif
               end else begin
                  bit_d   = bit_q + 1'b1;
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (tick) begin
               tx_d    = 1'b1;
               bit_d   = STOP_LAST;
               state_d = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (tick) begin
               if (bit_q != '0) begin
                  bit_d = bit_q - 1'b1;
               end else if (can_start) begin
                  start_frame = 1'b1;
               end else begin
                  busy_d  = 1'b0;
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase

      // Loading the head byte is shared by the idle start and the chained start from STOP.
      if (start_frame) begin
         pop     = 1'b1;
         shift_d = head;
         tx_d    = 1'b0;
         busy_d  = 1'b1;
         baud_d  = BAUD_LAST;
         bit_d   = '0;
         state_d = S_START;
`ifdef UART_TX_PARITY_EN
         par_d   = (^head) ^ PARITY_ODD[0];
`endif
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign uart_tx = tx_q;
   assign busy_o  = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: serial receiver model scoreboards every frame against the bytes pushed.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
   localparam int BD = 69;
`ifdef UART_TX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int FRAME = (10 + PB) * BD;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       tx_en = 1'b0, valid_i = 1'b0;
   logic [7:0] data_i = 8'h00;
   logic       ready_o, uart_tx, busy_o;
   logic [3:0] level_o;
   logic       tx_en2 = 1'b0, valid2 = 1'b0;
   logic [7:0] data2 = 8'h00;
   logic       ready2, tx2, busy2;
   logic [3:0] level2;

   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;
   logic        mon_en = 1'b1;
   logic [7:0]  exp_q[$];
   int unsigned start_t[$];
   int unsigned fall1[$];
   int unsigned fall2[$];
   logic        prev1 = 1'b1, prev2 = 1'b1;

   uart_tx_fifo u_dut (
      .clk(clk), .reset(reset), .tx_en(tx_en), .data_i(data_i), .valid_i(valid_i),
      .ready_o(ready_o), .uart_tx(uart_tx), .busy_o(busy_o), .level_o(level_o));

   uart_tx_fifo #(.STOP_BITS(2)) u_dut2 (
      .clk(clk), .reset(reset), .tx_en(tx_en2), .data_i(data2), .valid_i(valid2),
      .ready_o(ready2), .uart_tx(tx2), .busy_o(busy2), .level_o(level2));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      prev1 <= uart_tx;
      prev2 <= tx2;
      if (prev1 === 1'b1 && uart_tx === 1'b0) fall1.push_back(cyc);
      if (prev2 === 1'b1 && tx2 === 1'b0) fall2.push_back(cyc);
   end

   initial begin
      #2ms;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // 8N1 receiver model sampling at bit centres
   initial begin : rx_model
      logic prev, start_ok, stop_ok, par_ok;
      logic [7:0] b, e;
      int unsigned t0;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (mon_en && reset === 1'b1 && prev === 1'b1 && uart_tx === 1'b0) begin
            t0 = cyc;
            repeat (BD / 2) @(negedge clk);
            start_ok = (uart_tx === 1'b0);
            for (int i = 0; i < 8; i++) begin
               repeat (BD) @(negedge clk);
               b[i] = uart_tx;
            end
            par_ok = 1'b1;
`ifdef UART_TX_PARITY_EN
            repeat (BD) @(negedge clk);
            par_ok = (uart_tx === ^b);
`endif
            repeat (BD) @(negedge clk);
            stop_ok = (uart_tx === 1'b1);
            if (mon_en) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL rx_unexpected got=%h expected=none", b);
               end else begin
                  e = exp_q.pop_front();
                  if (b !== e || !start_ok || !stop_ok || !par_ok) begin
                     errors++;
                     $display("FAIL rx_frame got=%h expected=%h start_ok=%b stop_ok=%b parity_ok=%b",
                              b, e, start_ok, stop_ok, par_ok);
                  end
               end
               start_t.push_back(t0);
            end
            prev = 1'b1;
         end else begin
            prev = uart_tx;
         end
      end
   end

   function automatic logic exp_bit(input logic [7:0] b, input int k);
      int s;
      s = k / BD;
      if (s == 0) return 1'b0;
      if (s <= 8) return b[s-1];
`ifdef UART_TX_PARITY_EN
      if (s == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   // Call at a negedge; returns at the negedge after the accepting edge.
   task automatic push(input logic [7:0] b, output logic [3:0] lvl, output logic ok);
      int n;
      n = 0;
      ok = 1'b0;
      lvl = 4'd0;
      data_i = b;
      valid_i = 1'b1;
      while (ready_o !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) begin
         checks++;
         errors++;
         $display("FAIL push_timeout byte=%h ready=%b expected ready=1", b, ready_o);
         valid_i = 1'b0;
      end else begin
         lvl = level_o;
         @(posedge clk);
         exp_q.push_back(b);
         ok = 1'b1;
         @(negedge clk);
         valid_i = 1'b0;
      end
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (!(busy_o === 1'b0 && level_o === 4'd0 && exp_q.size() == 0) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 20000) begin
         errors++;
         $display("FAIL %s_idle_timeout busy=%b level=%0d pending=%0d expected idle", tag, busy_o, level_o, exp_q.size());
      end
      repeat (5) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (uart_tx !== 1'b1 || busy_o !== 1'b0 || ready_o !== 1'b1 || level_o !== 4'd0) begin
         errors++;
         $display("FAIL reset_state tx=%b busy=%b ready=%b level=%0d expected 1 0 1 0", uart_tx, busy_o, ready_o, level_o);
      end
      reset = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_basic();
      logic [3:0] lvl;
      logic ok, e;
      int bad_k;
      tx_en = 1'b1;
      push(8'h55, lvl, ok);
      checks++;
      if (uart_tx !== 1'b1 || level_o !== 4'd1) begin
         errors++;
         $display("FAIL basic_e0 tx=%b level=%0d expected 1 1", uart_tx, level_o);
      end
      @(negedge clk);
      bad_k = -1;
      for (int k = 0; k < FRAME; k++) begin
         e = exp_bit(8'h55, k);
         if (bad_k < 0 && (uart_tx !== e || busy_o !== 1'b1)) bad_k = k;
         @(negedge clk);
      end
      checks++;
      if (bad_k >= 0) begin
         errors++;
         $display("FAIL basic_wave first_bad_clock=%0d expected none", bad_k);
      end
      checks++;
      if (busy_o !== 1'b0 || uart_tx !== 1'b1) begin
         errors++;
         $display("FAIL basic_busy_fall busy=%b tx=%b expected 0 1 at %0d clocks", busy_o, uart_tx, FRAME);
      end
      wait_idle("basic");
   endtask

   task automatic test_back_to_back();
      logic [3:0] lvl;
      logic ok;
      int bad;
      tx_en = 1'b0;
      start_t.delete();
      for (int i = 0; i < 8; i++) push(8'(i), lvl, ok);
      checks++;
      if (level_o !== 4'd8 || ready_o !== 1'b0) begin
         errors++;
         $display("FAIL bp_full level=%0d ready=%b expected 8 0", level_o, ready_o);
      end
      data_i = 8'h08;
      valid_i = 1'b1;
      repeat (20) @(negedge clk);
      checks++;
      if (level_o !== 4'd8 || ready_o !== 1'b0 || uart_tx !== 1'b1) begin
         errors++;
         $display("FAIL bp_hold level=%0d ready=%b tx=%b expected 8 0 1", level_o, ready_o, uart_tx);
      end
      tx_en = 1'b1;
      push(8'h08, lvl, ok);
      checks++;
      if (!ok || lvl !== 4'd7) begin
         errors++;
         $display("FAIL bp_accept_level level=%0d expected 7", lvl);
      end
      wait_idle("bp");
      bad = 0;
      if (start_t.size() != 9) bad = 1;
      else for (int i = 1; i < 9; i++) if (start_t[i] - start_t[i-1] != FRAME) bad = 1;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL bp_gap frames=%0d first_spacing=%0d expected 9 frames spaced %0d",
                  start_t.size(), (start_t.size() > 1) ? start_t[1] - start_t[0] : 0, FRAME);
      end
   endtask

   task automatic test_hold();
      logic [3:0] lvl;
      logic ok;
      int n, bad;
      tx_en = 1'b1;
      push(8'hA3, lvl, ok);
      push(8'h3C, lvl, ok);
      repeat (98) @(negedge clk);
      tx_en = 1'b0;
      n = 0;
      while (busy_o !== 1'b0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (busy_o !== 1'b0 || n < FRAME - 110) begin
         errors++;
         $display("FAIL hold_complete busy=%b clocks_to_end=%0d expected busy 0 after about %0d", busy_o, n, FRAME - 100);
      end
      bad = 0;
      repeat (300) begin
         @(negedge clk);
         if (uart_tx !== 1'b1 || level_o !== 4'd1 || busy_o !== 1'b0) bad = 1;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL hold_line tx=%b level=%0d busy=%b expected 1 1 0 throughout", uart_tx, level_o, busy_o);
      end
      tx_en = 1'b1;
      wait_idle("hold");
   endtask

   task automatic test_reset_abort();
      logic [3:0] lvl;
      logic ok;
      int bad;
      tx_en = 1'b1;
      push(8'h52, lvl, ok);
      push(8'h81, lvl, ok);
      repeat (298) @(negedge clk);
      mon_en = 1'b0;
      reset = 1'b0;
      #1;
      checks++;
      if (uart_tx !== 1'b1 || level_o !== 4'd0 || busy_o !== 1'b0 || ready_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_async tx=%b level=%0d busy=%b ready=%b expected 1 0 0 1", uart_tx, level_o, busy_o, ready_o);
      end
      @(negedge clk);
      reset = 1'b1;
      exp_q.delete();
      bad = 0;
      repeat (2000) begin
         @(negedge clk);
         if (uart_tx !== 1'b1 || busy_o !== 1'b0) bad = 1;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL reset_no_frame tx=%b busy=%b expected line idle after reset", uart_tx, busy_o);
      end
      mon_en = 1'b1;
   endtask

   task automatic test_stop2();
      int n;
      int unsigned t_end;
      fall2.delete();
      tx_en2 = 1'b1;
      data2 = 8'hFF;
      valid2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      data2 = 8'h00;
      @(posedge clk);
      @(negedge clk);
      valid2 = 1'b0;
      n = 0;
      t_end = 0;
      while (n < 5000) begin
         @(negedge clk);
         n++;
         if (fall2.size() >= 2 && busy2 === 1'b0) begin
            t_end = cyc;
            break;
         end
      end
      checks++;
      if (fall2.size() != 2 || fall2[1] - fall2[0] - (9 + PB) * BD != 138) begin
         errors++;
         $display("FAIL stop2_period starts=%0d stop_clocks=%0d expected 2 starts 138 clocks",
                  fall2.size(), (fall2.size() >= 2) ? fall2[1] - fall2[0] - (9 + PB) * BD : 0);
      end
      checks++;
      if (fall2.size() < 2 || t_end - fall2[1] != (11 + PB) * BD || tx2 !== 1'b1) begin
         errors++;
         $display("FAIL stop2_frame_len len=%0d tx=%b expected %0d 1",
                  (fall2.size() >= 2) ? t_end - fall2[1] : 0, tx2, (11 + PB) * BD);
      end
      tx_en2 = 1'b0;
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      logic [3:0] lvl;
      logic ok, e;
      logic [7:0] bytes[2];
      int n;
      bytes[0] = 8'h07;
      bytes[1] = 8'h03;
      fall1.delete();
      tx_en = 1'b1;
      push(bytes[0], lvl, ok);
      push(bytes[1], lvl, ok);
      for (int f = 0; f < 2; f++) begin
         e = (f == 0) ? 1'b1 : 1'b0;
         n = 0;
         while (!(fall1.size() > f && cyc == fall1[f] + 9 * BD + BD / 2) && n < 3000) begin
            @(negedge clk);
            n++;
         end
         checks++;
         if (n >= 3000 || uart_tx !== e) begin
            errors++;
            $display("FAIL parity_bit byte=%h got=%b expected=%b", bytes[f], uart_tx, e);
         end
      end
      wait_idle("parity");
      checks++;
      if (fall1.size() != 2 || fall1[1] - fall1[0] != 759) begin
         errors++;
         $display("FAIL parity_frame_len starts=%0d len=%0d expected 2 759",
                  fall1.size(), (fall1.size() >= 2) ? fall1[1] - fall1[0] : 0);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_hold();
      test_reset_abort();
      test_stop2();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain pending=%0d expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
